// File: rtl/bitslice_pwr_pkg.sv
// bitslice_pwr_pkg
// Shared definitions for the bit_slice power-sequence controller:
//   - pwr_state_e : 4-bit FSM state encoding, also exported on the pwr_state port
//   - TMR_W       : width of the shared dwell/timeout down-counter
//   - *_DEFAULT   : default values for the controller parameters
//   - dwell_to_load() : converts a dwell length in cycles into a timer load value
// Optional build macro used by the controller: BITSLICE_PWR_STAGGER_EN.
package bitslice_pwr_pkg;

  localparam int unsigned TMR_W = 8;

  localparam int unsigned N_DOM_DEFAULT       = 2;
  localparam int unsigned ISO_SETUP_DEFAULT   = 2;
  localparam int unsigned RET_HOLD_DEFAULT    = 2;
  localparam int unsigned ACK_TIMEOUT_DEFAULT = 255;

  typedef enum logic [3:0] {
    PWR_ON      = 4'd0,
    PWR_DRAIN   = 4'd1,
    PWR_ISO     = 4'd2,
    PWR_SAVE    = 4'd3,
    PWR_MSLP    = 4'd4,
    PWR_PGOFF   = 4'd5,
    PWR_OFF     = 4'd6,
    PWR_PGON    = 4'd7,
    PWR_MWAKE   = 4'd8,
    PWR_RESTORE = 4'd9,
    PWR_DEISO   = 4'd10,
    PWR_ERR     = 4'd11
  } pwr_state_e;

  // The timer flags expiry when it reaches zero, and a state only reacts to
  // expiry on the cycle it sees it, so a dwell of N cycles needs a load of N-1.
  // A zero-length dwell is treated as the minimum dwell of one cycle.
  function automatic logic [TMR_W-1:0] dwell_to_load(input int unsigned cycles);
    logic [TMR_W-1:0] val;
    if (cycles == 0) begin
      val = '0;
    end else begin
      val = TMR_W'(cycles - 1);
    end
    return val;
  endfunction

endpackage

// File: rtl/bitslice_pwr_timer.sv
// bitslice_pwr_timer
// Loadable down-counter shared by every timed state of the power controller
// (isolation setup, retention hold and ack timeouts).
// Ports:
//   clk_i      in   1  clock, rising edge
//   reset_i    in   1  synchronous reset, active-high (counter cleared)
//   load_i     in   1  load value_i this cycle (has priority over counting)
//   value_i    in   W  value to load
//   expired_o  out  1  counter has reached zero
module bitslice_pwr_timer
  import bitslice_pwr_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over counting; otherwise count down and park at zero so the
  // expired flag stays up until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/bitslice_pwr_ctrl.sv
// bitslice_pwr_ctrl
// Power-sequence controller for the bit_slice datapath. A single pd_req pulse
// runs drain -> isolate -> retain -> memory sleep -> switch off; a single pu_req
// pulse runs the reverse. Any ack wait that runs too long parks the FSM in ERR
// with all outputs frozen until err_clr.
// Ports:
//   hclk               in   1      clock, rising edge
//   reset              in   1      synchronous reset, active-high (state ON, outputs 0)
//   pd_req             in   1      power-down request pulse (taken only in ON)
//   pu_req             in   1      power-up request pulse (taken only in OFF)
//   err_clr            in   1      leaves ERR
//   data_valid         in   1      datapath busy; power-down waits in DRAIN while high
//   PG_ack_signals     in   N_DOM  1 = domain i confirmed off
//   memory_ack         in   1      1 = memories confirmed asleep
//   shut_down_signals  out  N_DOM  1 = switch domain i off
//   isolation_signals  out  N_DOM  1 = clamp outputs of domain i
//   retention_signals  out  N_DOM  1 = retention registers hold state
//   memory_sleep       out  1      1 = request memory sleep
//   pwr_state          out  4      current state (pwr_state_e encoding)
//   busy               out  1      state is neither ON nor OFF
//   err_timeout        out  1      high while in ERR
// Build option BITSLICE_PWR_STAGGER_EN: when defined, domains are switched off
// one at a time from index 0 upward, each waiting for its own PG_ack bit with
// its own timeout, and switched on again from index N_DOM-1 downward. When not
// defined, all domains switch together with one shared ack wait.
module bitslice_pwr_ctrl
  import bitslice_pwr_pkg::*;
#(
  parameter int unsigned N_DOM       = N_DOM_DEFAULT,
  parameter int unsigned ISO_SETUP   = ISO_SETUP_DEFAULT,
  parameter int unsigned RET_HOLD    = RET_HOLD_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic             hclk,
  input  logic             reset,
  input  logic             pd_req,
  input  logic             pu_req,
  input  logic             err_clr,
  input  logic             data_valid,
  input  logic [N_DOM-1:0] PG_ack_signals,
  input  logic             memory_ack,
  output logic [N_DOM-1:0] shut_down_signals,
  output logic [N_DOM-1:0] isolation_signals,
  output logic [N_DOM-1:0] retention_signals,
  output logic             memory_sleep,
  output logic [3:0]       pwr_state,
  output logic             busy,
  output logic             err_timeout
);

  localparam logic [N_DOM-1:0] ALL_ON  = '1;
  localparam logic [N_DOM-1:0] ALL_OFF = '0;

  localparam logic [TMR_W-1:0] ISO_LOAD = dwell_to_load(ISO_SETUP);
  localparam logic [TMR_W-1:0] RET_LOAD = dwell_to_load(RET_HOLD);
  localparam logic [TMR_W-1:0] ACK_LOAD = dwell_to_load(ACK_TIMEOUT);

`ifdef BITSLICE_PWR_STAGGER_EN
  localparam int unsigned      IDX_W    = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOM - 1);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
`endif

  pwr_state_e       state_q;
  pwr_state_e       state_d;
  logic [N_DOM-1:0] sd_q;
  logic [N_DOM-1:0] sd_d;
  logic [N_DOM-1:0] iso_q;
  logic [N_DOM-1:0] iso_d;
  logic [N_DOM-1:0] ret_q;
  logic [N_DOM-1:0] ret_d;
  logic             msl_q;
  logic             msl_d;

  logic             step_load;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_expired;

  bitslice_pwr_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i     (hclk),
    .reset_i   (reset),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  // Next-state and next-output logic. Each output register only changes on
  // the transition into the state that owns it, so levels carry over through
  // later states. ERR simply holds everything. On leaving ERR the outputs are
  // forced to the canonical levels of the destination (all 0 for ON, fully
  // powered-down for OFF) so ON/OFF always present a consistent picture.
  always_comb begin
    state_d   = state_q;
    sd_d      = sd_q;
    iso_d     = iso_q;
    ret_d     = ret_q;
    msl_d     = msl_q;
    step_load = 1'b0;
`ifdef BITSLICE_PWR_STAGGER_EN
    idx_d     = idx_q;
`endif

    case (state_q)
      PWR_ON: begin
        if (pd_req) begin
          state_d = PWR_DRAIN;
        end
      end

      PWR_DRAIN: begin
        if (!data_valid) begin
          state_d = PWR_ISO;
          iso_d   = ALL_ON;
        end
      end

      PWR_ISO: begin
        if (tmr_expired) begin
          state_d = PWR_SAVE;
          ret_d   = ALL_ON;
        end
      end

      PWR_SAVE: begin
        state_d = PWR_MSLP;
        msl_d   = 1'b1;
      end

      PWR_MSLP: begin
        if (memory_ack) begin
          state_d = PWR_PGOFF;
`ifdef BITSLICE_PWR_STAGGER_EN
          sd_d[0] = 1'b1;
          idx_d   = '0;
`else
          sd_d    = ALL_ON;
`endif
        end else if (tmr_expired) begin
          state_d = PWR_ERR;
        end
      end

      PWR_PGOFF: begin
`ifdef BITSLICE_PWR_STAGGER_EN
        // Walk upward one domain per ack; each step reloads the timeout.
        if (PG_ack_signals[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            state_d = PWR_OFF;
          end else begin
            idx_d                          = idx_q + IDX_W'(1);
            sd_d[idx_q + IDX_W'(1)] = 1'b1;
            step_load                      = 1'b1;
          end
        end else if (tmr_expired) begin
          state_d = PWR_ERR;
        end
`else
        if (PG_ack_signals == ALL_ON) begin
          state_d = PWR_OFF;
        end else if (tmr_expired) begin
          state_d = PWR_ERR;
        end
`endif
      end

      PWR_OFF: begin
        if (pu_req) begin
          state_d = PWR_PGON;
`ifdef BITSLICE_PWR_STAGGER_EN
          sd_d[N_DOM-1] = 1'b0;
          idx_d         = LAST_IDX;
`else
          sd_d          = ALL_OFF;
`endif
        end
      end

      PWR_PGON: begin
`ifdef BITSLICE_PWR_STAGGER_EN
        // Walk downward one domain per released ack.
        if (!PG_ack_signals[idx_q]) begin
          if (idx_q == '0) begin
            state_d = PWR_MWAKE;
            msl_d   = 1'b0;
          end else begin
            idx_d                          = idx_q - IDX_W'(1);
            sd_d[idx_q - IDX_W'(1)] = 1'b0;
            step_load                      = 1'b1;
          end
        end else if (tmr_expired) begin
          state_d = PWR_ERR;
        end
`else
        if (PG_ack_signals == ALL_OFF) begin
          state_d = PWR_MWAKE;
          msl_d   = 1'b0;
        end else if (tmr_expired) begin
          state_d = PWR_ERR;
        end
`endif
      end

      PWR_MWAKE: begin
        if (!memory_ack) begin
          state_d = PWR_RESTORE;
          ret_d   = ALL_OFF;
        end else if (tmr_expired) begin
          state_d = PWR_ERR;
        end
      end

      PWR_RESTORE: begin
        if (tmr_expired) begin
          state_d = PWR_DEISO;
          iso_d   = ALL_OFF;
        end
      end

      PWR_DEISO: begin
        state_d = PWR_ON;
      end

      PWR_ERR: begin
        if (err_clr) begin
          if (PG_ack_signals == ALL_ON) begin
            state_d = PWR_OFF;
            sd_d    = ALL_ON;
            iso_d   = ALL_ON;
            ret_d   = ALL_ON;
            msl_d   = 1'b1;
          end else begin
            state_d = PWR_ON;
            sd_d    = ALL_OFF;
            iso_d   = ALL_OFF;
            ret_d   = ALL_OFF;
            msl_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = PWR_ON;
        sd_d    = ALL_OFF;
        iso_d   = ALL_OFF;
        ret_d   = ALL_OFF;
        msl_d   = 1'b0;
      end
    endcase

    // The timer reloads on every state entry (and on every staggered domain
    // step) with the dwell or timeout belonging to the state being entered.
    tmr_load = (state_d != state_q) || step_load;
    case (state_d)
      PWR_ISO:     tmr_value = ISO_LOAD;
      PWR_RESTORE: tmr_value = RET_LOAD;
      default:     tmr_value = ACK_LOAD;
    endcase
  end

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q <= PWR_ON;
      sd_q    <= ALL_OFF;
      iso_q   <= ALL_OFF;
      ret_q   <= ALL_OFF;
      msl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sd_q    <= sd_d;
      iso_q   <= iso_d;
      ret_q   <= ret_d;
      msl_q   <= msl_d;
    end
  end

`ifdef BITSLICE_PWR_STAGGER_EN
  // Domain pointer used while walking domains one at a time.
  always_ff @(posedge hclk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end
`endif

  assign shut_down_signals = sd_q;
  assign isolation_signals = iso_q;
  assign retention_signals = ret_q;
  assign memory_sleep      = msl_q;
  assign pwr_state         = state_q;
  assign busy              = (state_q != PWR_ON) && (state_q != PWR_OFF);
  assign err_timeout       = (state_q == PWR_ERR);

endmodule
